// File: rtl/nn_pixel_frame_queue_if.sv
// nn_pixel_frame_queue_if: pixel stream in, frame FIFO out, plus status pulses
interface nn_pixel_frame_queue_if #(
  parameter int PIXEL_BIT_WIDTH = 1,
  parameter int INPUT_NODES = 6,
  parameter int QUEUE_DEPTH = 4
);
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  logic inputsInbound;
  logic [PIXEL_BIT_WIDTH-1:0] inputPixel;
  logic readyForInputs;
  logic [INPUT_NODES*PIXEL_BIT_WIDTH-1:0] frameOut;
  logic frameValid;
  logic frameReady;
  logic [CNT_W-1:0] queueCount;
  logic shortFrame;
  logic overflowDrop;
  modport slave (
    input inputsInbound, inputPixel, frameReady,
    output readyForInputs, frameOut, frameValid, queueCount, shortFrame, overflowDrop
  );
  modport master (
    output inputsInbound, inputPixel, frameReady,
    input readyForInputs, frameOut, frameValid, queueCount, shortFrame, overflowDrop
  );
endinterface

// File: rtl/nn_pixel_frame_queue.sv
// nn_pixel_frame_queue: packs a serial pixel stream into frames and queues whole frames in a FWFT FIFO
module nn_pixel_frame_queue #(
  parameter int PIXEL_BIT_WIDTH = 1,
  parameter int INPUT_NODES = 6,
  parameter int QUEUE_DEPTH = 4
) (
  input logic masterClk,
  input logic reset,
  nn_pixel_frame_queue_if.slave bus
);
  localparam int IDX_W = INPUT_NODES > 1 ? $clog2(INPUT_NODES) : 1;
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int PTR_W = QUEUE_DEPTH > 1 ? $clog2(QUEUE_DEPTH) : 1;
  localparam int FW = INPUT_NODES * PIXEL_BIT_WIDTH;
  typedef enum logic [1:0] {IDLE, FILL, DROP} state_t;
  state_t state, stateNext;
  logic [IDX_W-1:0] pixIdx, pixIdxNext;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] rdPtr, wrPtr;
  logic [FW-1:0] assembly, assemblyNext;
  logic [FW-1:0] mem [QUEUE_DEPTH];
  logic push, pop, shortNext, dropNext, shortReg, dropReg, slotFree, notEmpty, lastPixel;
  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return p == PTR_W'(QUEUE_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign slotFree = count < CNT_W'(QUEUE_DEPTH);
  assign notEmpty = count != '0;
  assign pop = notEmpty && bus.frameReady;
  assign lastPixel = pixIdx == IDX_W'(INPUT_NODES - 1);
  assign bus.readyForInputs = slotFree;
  assign bus.frameValid = notEmpty;
  assign bus.queueCount = count;
  assign bus.frameOut = notEmpty ? mem[rdPtr] : '0;
  assign bus.shortFrame = shortReg;
  assign bus.overflowDrop = dropReg;
  // Frame assembly FSM: start only with a free slot, push on the last pixel, abort on a gap
  always_comb begin
    stateNext = state;
    pixIdxNext = pixIdx;
    assemblyNext = assembly;
    push = 1'b0;
    shortNext = 1'b0;
    dropNext = 1'b0;
    case (state)
      IDLE: if (bus.inputsInbound) begin
        if (slotFree) begin
          assemblyNext[0 +: PIXEL_BIT_WIDTH] = bus.inputPixel;
          if (INPUT_NODES == 1) push = 1'b1;
          else begin
            stateNext = FILL;
            pixIdxNext = IDX_W'(1);
          end
        end else begin
          dropNext = 1'b1;
          stateNext = DROP;
        end
      end
      FILL: if (bus.inputsInbound) begin
        assemblyNext[pixIdx*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH] = bus.inputPixel;
        push = lastPixel;
        pixIdxNext = lastPixel ? '0 : pixIdx + 1'b1;
        stateNext = lastPixel ? IDLE : FILL;
      end else begin
        shortNext = 1'b1;
        pixIdxNext = '0;
        stateNext = IDLE;
      end
      DROP: stateNext = bus.inputsInbound ? DROP : IDLE;
      default: stateNext = IDLE;
    endcase
  end
  // State, pointers, occupancy and status pulses
  always_ff @(posedge masterClk) begin
    if (!reset) begin
      state <= IDLE;
      pixIdx <= '0;
      assembly <= '0;
      count <= '0;
      rdPtr <= '0;
      wrPtr <= '0;
      shortReg <= 1'b0;
      dropReg <= 1'b0;
    end else begin
      state <= stateNext;
      pixIdx <= pixIdxNext;
      assembly <= assemblyNext;
      count <= push && !pop ? count + 1'b1 : !push && pop ? count - 1'b1 : count;
      wrPtr <= push ? nextPtr(wrPtr) : wrPtr;
      rdPtr <= pop ? nextPtr(rdPtr) : rdPtr;
      shortReg <= shortNext;
      dropReg <= dropNext;
    end
  end
  // Frame storage; the completed frame includes the pixel sampled on the pushing edge
  always_ff @(posedge masterClk) begin
    if (push) mem[wrPtr] <= assemblyNext;
  end
endmodule

// File: tb/tb_nn_pixel_frame_queue.sv
// tb_nn_pixel_frame_queue: directed checks of frame packing, queueing, overflow, short frames and reset
module tb_nn_pixel_frame_queue;
  logic masterClk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 masterClk = ~masterClk;
  nn_pixel_frame_queue_if #(.PIXEL_BIT_WIDTH(1), .INPUT_NODES(6), .QUEUE_DEPTH(4)) ifA ();
  nn_pixel_frame_queue_if #(.PIXEL_BIT_WIDTH(4), .INPUT_NODES(6), .QUEUE_DEPTH(2)) ifB ();
  nn_pixel_frame_queue #(.PIXEL_BIT_WIDTH(1), .INPUT_NODES(6), .QUEUE_DEPTH(4)) dutA (
    .masterClk(masterClk), .reset(reset), .bus(ifA.slave));
  nn_pixel_frame_queue #(.PIXEL_BIT_WIDTH(4), .INPUT_NODES(6), .QUEUE_DEPTH(2)) dutB (
    .masterClk(masterClk), .reset(reset), .bus(ifB.slave));
  task automatic tick();
    @(posedge masterClk);
    #1;
  endtask
  task automatic sendA(input logic [5:0] f);
    for (int i = 0; i < 6; i++) begin
      ifA.inputsInbound = 1'b1;
      ifA.inputPixel = f[i];
      tick();
    end
  endtask
  task automatic idleA();
    ifA.inputsInbound = 1'b0;
    tick();
  endtask
  task automatic popA();
    ifA.frameReady = 1'b1;
    tick();
    ifA.frameReady = 1'b0;
  endtask
  task automatic sendB(input logic [23:0] f);
    for (int i = 0; i < 6; i++) begin
      ifB.inputsInbound = 1'b1;
      ifB.inputPixel = f[i*4 +: 4];
      tick();
    end
  endtask
  task automatic idleB();
    ifB.inputsInbound = 1'b0;
    tick();
  endtask
  task automatic popB();
    ifB.frameReady = 1'b1;
    tick();
    ifB.frameReady = 1'b0;
  endtask
  function automatic logic [23:0] mkB(input int k);
    logic [23:0] m;
    for (int i = 0; i < 6; i++) m[i*4 +: 4] = 4'(k * 3 + i + 7);
    return m;
  endfunction
  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    checks++; if (ifA.readyForInputs !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ifA.readyForInputs); end
    checks++; if (ifA.frameValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ifA.frameValid); end
    checks++; if (ifA.frameOut !== 6'h00) begin errors++; $display("FAIL reset_frame got %h exp 00", ifA.frameOut); end
    checks++; if (ifA.queueCount !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", ifA.queueCount); end
    checks++; if (ifA.shortFrame !== 1'b0 || ifA.overflowDrop !== 1'b0) begin errors++; $display("FAIL reset_pulses got %b%b exp 00", ifA.shortFrame, ifA.overflowDrop); end
    checks++; if (ifB.queueCount !== 2'd0 || ifB.readyForInputs !== 1'b1) begin errors++; $display("FAIL reset_b got cnt %0d rdy %b exp 0 1", ifB.queueCount, ifB.readyForInputs); end
    reset = 1'b1;
    tick();
  endtask
  task automatic test_single_frame();
    sendA(6'b010110);
    checks++; if (ifA.frameValid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", ifA.frameValid); end
    checks++; if (ifA.frameOut !== 6'b010110) begin errors++; $display("FAIL single_frame got %b exp 010110", ifA.frameOut); end
    checks++; if (ifA.queueCount !== 3'd1) begin errors++; $display("FAIL single_count got %0d exp 1", ifA.queueCount); end
    idleA();
    popA();
    checks++; if (ifA.frameValid !== 1'b0 || ifA.queueCount !== 3'd0) begin errors++; $display("FAIL single_pop got v %b cnt %0d exp 0 0", ifA.frameValid, ifA.queueCount); end
  endtask
  task automatic test_overflow();
    logic [5:0] fr [4];
    fr = '{6'h15, 6'h2A, 6'h33, 6'h0F};
    for (int k = 0; k < 4; k++) sendA(fr[k]);
    checks++; if (ifA.queueCount !== 3'd4) begin errors++; $display("FAIL ovf_full_count got %0d exp 4", ifA.queueCount); end
    checks++; if (ifA.readyForInputs !== 1'b0) begin errors++; $display("FAIL ovf_ready got %b exp 0", ifA.readyForInputs); end
    checks++; if (ifA.overflowDrop !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", ifA.overflowDrop); end
    ifA.inputsInbound = 1'b1;
    ifA.inputPixel = 1'b1;
    tick();
    checks++; if (ifA.overflowDrop !== 1'b1) begin errors++; $display("FAIL ovf_pulse got %b exp 1", ifA.overflowDrop); end
    tick();
    checks++; if (ifA.overflowDrop !== 1'b0) begin errors++; $display("FAIL ovf_pulse_end got %b exp 0", ifA.overflowDrop); end
    for (int i = 0; i < 4; i++) tick();
    idleA();
    checks++; if (ifA.queueCount !== 3'd4) begin errors++; $display("FAIL ovf_count_kept got %0d exp 4", ifA.queueCount); end
    ifA.frameReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (ifA.frameValid !== 1'b1 || ifA.frameOut !== fr[k]) begin errors++; $display("FAIL ovf_order%0d got v %b %h exp 1 %h", k, ifA.frameValid, ifA.frameOut, fr[k]); end
      tick();
    end
    ifA.frameReady = 1'b0;
    checks++; if (ifA.frameValid !== 1'b0 || ifA.queueCount !== 3'd0) begin errors++; $display("FAIL ovf_drained got v %b cnt %0d exp 0 0", ifA.frameValid, ifA.queueCount); end
  endtask
  task automatic test_short_frame();
    for (int i = 0; i < 3; i++) begin
      ifA.inputsInbound = 1'b1;
      ifA.inputPixel = 1'b1;
      tick();
    end
    ifA.inputsInbound = 1'b0;
    tick();
    checks++; if (ifA.shortFrame !== 1'b1) begin errors++; $display("FAIL short_pulse got %b exp 1", ifA.shortFrame); end
    checks++; if (ifA.queueCount !== 3'd0) begin errors++; $display("FAIL short_count got %0d exp 0", ifA.queueCount); end
    tick();
    checks++; if (ifA.shortFrame !== 1'b0) begin errors++; $display("FAIL short_pulse_end got %b exp 0", ifA.shortFrame); end
    sendA(6'b101101);
    checks++; if (ifA.frameOut !== 6'b101101 || ifA.queueCount !== 3'd1) begin errors++; $display("FAIL short_next got %b cnt %0d exp 101101 1", ifA.frameOut, ifA.queueCount); end
    idleA();
    popA();
  endtask
  task automatic test_back_to_back();
    logic [5:0] b;
    b = 6'h1E;
    sendA(6'h21);
    idleA();
    for (int i = 0; i < 6; i++) begin
      ifA.inputsInbound = 1'b1;
      ifA.inputPixel = b[i];
      ifA.frameReady = i == 5;
      tick();
    end
    ifA.frameReady = 1'b0;
    checks++; if (ifA.queueCount !== 3'd1) begin errors++; $display("FAIL pushpop_count got %0d exp 1", ifA.queueCount); end
    checks++; if (ifA.frameOut !== 6'h1E) begin errors++; $display("FAIL pushpop_head got %h exp 1e", ifA.frameOut); end
    idleA();
    popA();
    checks++; if (ifA.queueCount !== 3'd0) begin errors++; $display("FAIL pushpop_drain got %0d exp 0", ifA.queueCount); end
  endtask
  task automatic test_reset_midfill();
    sendA(6'h01);
    sendA(6'h02);
    for (int i = 0; i < 2; i++) begin
      ifA.inputsInbound = 1'b1;
      ifA.inputPixel = 1'b1;
      tick();
    end
    checks++; if (ifA.queueCount !== 3'd2) begin errors++; $display("FAIL midrst_pre got %0d exp 2", ifA.queueCount); end
    reset = 1'b0;
    ifA.inputsInbound = 1'b0;
    tick();
    checks++; if (ifA.queueCount !== 3'd0 || ifA.frameValid !== 1'b0 || ifA.readyForInputs !== 1'b1) begin errors++; $display("FAIL midrst_state got cnt %0d v %b r %b exp 0 0 1", ifA.queueCount, ifA.frameValid, ifA.readyForInputs); end
    checks++; if (ifA.frameOut !== 6'h00 || ifA.shortFrame !== 1'b0 || ifA.overflowDrop !== 1'b0) begin errors++; $display("FAIL midrst_out got %h %b%b exp 00 00", ifA.frameOut, ifA.shortFrame, ifA.overflowDrop); end
    reset = 1'b1;
    tick();
    sendA(6'h2D);
    checks++; if (ifA.frameOut !== 6'h2D || ifA.queueCount !== 3'd1) begin errors++; $display("FAIL midrst_next got %h cnt %0d exp 2d 1", ifA.frameOut, ifA.queueCount); end
    idleA();
    popA();
  endtask
  task automatic test_wide_wrap();
    sendB(24'h654321);
    checks++; if (ifB.frameOut !== 24'h654321 || ifB.queueCount !== 2'd1) begin errors++; $display("FAIL wide_frame got %h cnt %0d exp 654321 1", ifB.frameOut, ifB.queueCount); end
    idleB();
    popB();
    checks++; if (ifB.frameValid !== 1'b0) begin errors++; $display("FAIL wide_pop got %b exp 0", ifB.frameValid); end
    sendB(mkB(0));
    idleB();
    for (int k = 1; k < 6; k++) begin
      sendB(mkB(k));
      idleB();
      checks++; if (ifB.queueCount !== 2'd2 || ifB.readyForInputs !== 1'b0) begin errors++; $display("FAIL wrap_full%0d got cnt %0d r %b exp 2 0", k, ifB.queueCount, ifB.readyForInputs); end
      checks++; if (ifB.frameOut !== mkB(k - 1)) begin errors++; $display("FAIL wrap_head%0d got %h exp %h", k, ifB.frameOut, mkB(k - 1)); end
      popB();
    end
    checks++; if (ifB.frameOut !== mkB(5)) begin errors++; $display("FAIL wrap_last got %h exp %h", ifB.frameOut, mkB(5)); end
    popB();
    checks++; if (ifB.frameValid !== 1'b0 || ifB.queueCount !== 2'd0) begin errors++; $display("FAIL wrap_drain got v %b cnt %0d exp 0 0", ifB.frameValid, ifB.queueCount); end
  endtask
  initial begin
    ifA.inputsInbound = 1'b0;
    ifA.inputPixel = '0;
    ifA.frameReady = 1'b0;
    ifB.inputsInbound = 1'b0;
    ifB.inputPixel = '0;
    ifB.frameReady = 1'b0;
    test_reset();
    test_single_frame();
    test_overflow();
    test_short_frame();
    test_back_to_back();
    test_reset_midfill();
    test_wide_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
